keypad_debouncer: RTL and testbench
===================================

# keypad_debouncer

Front end for the decimal keypad: synchronizes ten raw key lines, debounces them, rejects multi-key presses and presents a clean, held one-hot code. Its `key_onehot` output drives the 10-line input of the BCD encoder directly. `key_valid` and `key_strobe` are needed downstream because the encoder maps both key 0 and "no key" to 0000.

## Interface
- `DEBOUNCE_CYCLES`, default 16: cycles a pattern must stay stable to be accepted; legal range ≥2.
- `REPEAT_DELAY`, default 500000: cycles from acceptance to the first auto-repeat strobe; used only with `KEYPAD_REPEAT_EN`.
- `REPEAT_PERIOD`, default 100000: cycles between subsequent auto-repeat strobes; used only with `KEYPAD_REPEAT_EN`.
- `clk`, input, 1: single clock; all logic on rising edge.
- `rst_n`, input, 1: reset, asynchronous and active-low.
- `keys_raw`, input, 10: asynchronous key lines, active-high, bit i = key i.
- `key_onehot`, output, 10: accepted key, one-hot, held while pressed; 0 when no key is accepted.
- `key_valid`, output, 1: high while `key_onehot` holds an accepted key.
- `key_strobe`, output, 1: one-cycle pulse per accepted press, and per repeat when repeat is enabled.
- `multi_err`, output, 1: one-cycle pulse when a stable pattern with more than one bit set is rejected.

## Operation
- `keys_raw` passes through a 2-flop synchronizer to produce `keys_s`. No other logic uses `keys_raw`.
- The FSM has four states:
  - **IDLE**
    - Stays in IDLE while `keys_s` == 0.
    - When `keys_s` is nonzero: capture `cand` = `keys_s`, clear `cnt`, go to DEBOUNCE.
  - **DEBOUNCE**
    - If `keys_s` == 0, go to IDLE.
    - Else if `keys_s` ≠ `cand`, reload `cand` and clear `cnt`.
    - Else increment `cnt`.
    - When `cnt` == `DEBOUNCE_CYCLES`-1 and `keys_s` == `cand`:
      - If `cand` is one-hot: load `key_onehot` = `cand`, pulse `key_strobe`, go to PRESSED.
      - Otherwise: pulse `multi_err`, go to RELEASE.
  - **PRESSED**
    - `key_valid`=1.
    - Any `keys_s` ≠ `key_onehot` (release, second key, or key change) goes to RELEASE with `cnt` cleared.
    - `key_onehot` and `key_valid` stay held through RELEASE.
  - **RELEASE**
    - Requires `keys_s` == 0 for `DEBOUNCE_CYCLES` consecutive cycles; any nonzero sample clears `cnt`.
    - On completion: `key_onehot` is cleared to 0, `key_valid` goes to 0, go to IDLE.
- A new press is never accepted without a full debounced release first; holding one key and adding a second never produces a second strobe.
- `cnt` width is `$clog2(max(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD))`. `cnt` saturates and never wraps.
- `key_strobe` and `multi_err` are never high in the same cycle.

## Timing
- Reset values: state=IDLE, `key_onehot`=0, `key_valid`=0, `key_strobe`=0, `multi_err`=0, synchronizer flops=0, `cnt`=0.
- Reset mid-press returns to IDLE immediately. A key still held after reset is re-debounced from scratch.
- Press latency: `keys_raw` stable from clock edge k gives `key_strobe` high for exactly the cycle after edge k+`DEBOUNCE_CYCLES`+2.
- `key_onehot` and `key_valid` update on the same edge that raises `key_strobe`.
- Release latency: `keys_raw` at 0 from edge r gives `key_valid` low after edge r+`DEBOUNCE_CYCLES`+2, when starting from PRESSED.
- A glitch shorter than `DEBOUNCE_CYCLES` cycles produces no output change.
- All outputs are registered.

## Configuration
- `KEYPAD_REPEAT_EN` defined: in PRESSED, a repeat counter runs. It pulses `key_strobe` `REPEAT_DELAY` cycles after acceptance, then every `REPEAT_PERIOD` cycles while the key is held. Leaving PRESSED stops and clears the repeat counter.
- `KEYPAD_REPEAT_EN` undefined: exactly one `key_strobe` per press; no repeat logic is synthesized and the `REPEAT_*` parameters have no effect.

## Structure
- Shared package `keypad_pkg` holds:
  - `NUM_KEYS` = 10
  - the state enum `kp_state_t` {IDLE, DEBOUNCE, PRESSED, RELEASE}
  - a one-hot check function `is_onehot()`
- One sub-module: `key_sync`, a parameterized-width 2-flop synchronizer with async active-low reset.

## Test plan
Run all scenarios with `DEBOUNCE_CYCLES`=4.
- Clean press of key 7 from edge 10 → `key_strobe` high only in the cycle after edge 16; `key_onehot`=0x080 and `key_valid`=1 from then.
- Key 3 bouncing 1-2-cycle pulses for 6 cycles, then stable → exactly one strobe with `key_onehot`=0x008, 6 cycles after it settles; no output during the bounce.
- Keys 2 and 5 pressed together, stable → one `multi_err` pulse, no strobe, `key_valid` stays 0; after release and a new press of key 0, a strobe with 0x001.
- Key 9 held, key 1 added, both released → single strobe with 0x200. `key_valid` drops 6 cycles after full release.
- `rst_n` asserted while key 4 is in PRESSED → all outputs 0 immediately. After `rst_n` deasserts with key 4 still held, a new strobe occurs 6 cycles later.
- Repeat check, with `KEYPAD_REPEAT_EN`, `REPEAT_DELAY`=20, `REPEAT_PERIOD`=8: key 6 held for 60 cycles after acceptance → strobes at +0, +20, +28, +36, +44, +52. Without the macro → strobe at +0 only.

Source files
------------

// File: rtl/keypad_pkg.sv
// keypad_pkg: shared constants, FSM state type and helpers for the keypad front end.
package keypad_pkg;
    localparam int NUM_KEYS = 10;
    typedef enum logic [1:0] {IDLE, DEBOUNCE, PRESSED, RELEASE} kp_state_t;
    function automatic logic is_onehot(input logic [NUM_KEYS-1:0] v);
        return (v != '0) && ((v & (v - 1'b1)) == '0);
    endfunction
    function automatic int max3(input int a, input int b, input int c);
        return (a > b) ? ((a > c) ? a : c) : ((b > c) ? b : c);
    endfunction
endpackage

// File: rtl/key_sync.sv
// key_sync: parameterized-width 2-flop synchronizer with async active-low reset.
module key_sync #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    logic [W-1:0] s1;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            s1 <= '0;
            q  <= '0;
        end else begin
            s1 <= d;
            q  <= s1;
        end
endmodule

// File: rtl/keypad_debouncer.sv
// keypad_debouncer: synchronizes, debounces and one-hot validates ten key lines.
// Optional auto-repeat of key_strobe while held is enabled by defining KEYPAD_REPEAT_EN.
module keypad_debouncer import keypad_pkg::*; #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int REPEAT_DELAY    = 500000,
    parameter int REPEAT_PERIOD   = 100000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NUM_KEYS-1:0] keys_raw,
    output logic [NUM_KEYS-1:0] key_onehot,
    output logic                key_valid,
    output logic                key_strobe,
    output logic                multi_err
);
    localparam int CW = $clog2(max3(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD));
    localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);

    kp_state_t           state, state_n;
    logic [NUM_KEYS-1:0] keys_s, cand, cand_n, onehot_n;
    logic [CW-1:0]       cnt, cnt_n, cnt_inc;
    logic                valid_n, strobe_n, err_n;
`ifdef KEYPAD_REPEAT_EN
    localparam logic [CW-1:0] DLY_LAST = CW'(REPEAT_DELAY - 1);
    localparam logic [CW-1:0] PER_LAST = CW'(REPEAT_PERIOD - 1);
    logic rep, rep_n;
`endif

    key_sync #(.W(NUM_KEYS)) u_sync (.clk(clk), .rst_n(rst_n), .d(keys_raw), .q(keys_s));

    assign cnt_inc = (cnt == '1) ? cnt : cnt + 1'b1;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state      <= IDLE;
            cand       <= '0;
            cnt        <= '0;
            key_onehot <= '0;
            key_valid  <= 1'b0;
            key_strobe <= 1'b0;
            multi_err  <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
            rep        <= 1'b0;
`endif
        end else begin
            state      <= state_n;
            cand       <= cand_n;
            cnt        <= cnt_n;
            key_onehot <= onehot_n;
            key_valid  <= valid_n;
            key_strobe <= strobe_n;
            multi_err  <= err_n;
`ifdef KEYPAD_REPEAT_EN
            rep        <= rep_n;
`endif
        end

    always_comb begin
        state_n  = state;
        cand_n   = cand;
        cnt_n    = cnt;
        onehot_n = key_onehot;
        valid_n  = key_valid;
        strobe_n = 1'b0;
        err_n    = 1'b0;
`ifdef KEYPAD_REPEAT_EN
        rep_n    = (state == PRESSED) ? rep : 1'b0;
`endif
        case (state)
            IDLE:
                if (keys_s != '0) begin
                    cand_n  = keys_s;
                    cnt_n   = '0;
                    state_n = DEBOUNCE;
                end
            DEBOUNCE:
                if (keys_s == '0) state_n = IDLE;
                else if (keys_s != cand) begin
                    cand_n = keys_s;
                    cnt_n  = '0;
                end else if (cnt == DB_LAST) begin
                    cnt_n = '0;
                    if (is_onehot(cand)) begin
                        onehot_n = cand;
                        valid_n  = 1'b1;
                        strobe_n = 1'b1;
                        state_n  = PRESSED;
                    end else begin
                        err_n   = 1'b1;
                        state_n = RELEASE;
                    end
                end else cnt_n = cnt_inc;
            PRESSED:
                if (keys_s != key_onehot) begin
                    cnt_n   = '0;
                    state_n = RELEASE;
                end
`ifdef KEYPAD_REPEAT_EN
                // cnt doubles as the repeat timer while the key is held
                else if (cnt == (rep ? PER_LAST : DLY_LAST)) begin
                    strobe_n = 1'b1;
                    rep_n    = 1'b1;
                    cnt_n    = '0;
                end else cnt_n = cnt_inc;
`endif
            RELEASE:
                if (keys_s != '0) cnt_n = '0;
                else if (cnt == DB_LAST) begin
                    onehot_n = '0;
                    valid_n  = 1'b0;
                    cnt_n    = '0;
                    state_n  = IDLE;
                end else cnt_n = cnt_inc;
            default: state_n = IDLE;
        endcase
    end
endmodule

// File: tb/tb_keypad_debouncer.sv
// tb_keypad_debouncer: table-driven directed checks of keypad_debouncer with DEBOUNCE_CYCLES=4.
module tb_keypad_debouncer;
    logic       clk = 1'b0, rst_n = 1'b0;
    logic [9:0] keys_raw = '0, key_onehot;
    logic       key_valid, key_strobe, multi_err;
    int errors = 0, checks = 0;
    int nstb, nerr, first, last, fall, both = 0;

    typedef struct {
        logic [9:0] keys;
        int         n;
        int         nstb;
        int         first;
        int         last;
        int         nerr;
        logic [9:0] onehot;
        logic       valid;
        int         fall;
    } vec_t;
    vec_t tbl[$];

    keypad_debouncer #(.DEBOUNCE_CYCLES(4), .REPEAT_DELAY(20), .REPEAT_PERIOD(8)) dut (
        .clk(clk), .rst_n(rst_n), .keys_raw(keys_raw), .key_onehot(key_onehot),
        .key_valid(key_valid), .key_strobe(key_strobe), .multi_err(multi_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // drive keys for n cycles, recording strobe/err activity and the first valid fall
    task automatic apply(input logic [9:0] k, input int n);
        logic pv;
        keys_raw = k;
        nstb = 0; nerr = 0; first = 0; last = 0; fall = 0;
        for (int t = 1; t <= n; t++) begin
            pv = key_valid;
            @(posedge clk); #1;
            if (key_strobe) begin
                nstb++;
                if (first == 0) first = t;
                last = t;
            end
            if (multi_err) nerr++;
            if (key_strobe && multi_err) both = 1;
            if (pv && !key_valid && fall == 0) fall = t;
        end
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, ".onehot"}, key_onehot, 0);
        chk({tag, ".valid"}, key_valid, 0);
        chk({tag, ".strobe"}, key_strobe, 0);
        chk({tag, ".err"}, multi_err, 0);
    endtask

    initial begin
        tbl.push_back('{10'h080, 10, 1, 7, 7, 0, 10'h080, 1'b1, 0});
        tbl.push_back('{10'h000, 10, 0, 0, 0, 0, 10'h000, 1'b0, 7});
        tbl.push_back('{10'h008,  1, 0, 0, 0, 0, 10'h000, 1'b0, 0});
        tbl.push_back('{10'h000,  2, 0, 0, 0, 0, 10'h000, 1'b0, 0});
        tbl.push_back('{10'h008,  2, 0, 0, 0, 0, 10'h000, 1'b0, 0});
        tbl.push_back('{10'h000,  1, 0, 0, 0, 0, 10'h000, 1'b0, 0});
        tbl.push_back('{10'h008, 10, 1, 7, 7, 0, 10'h008, 1'b1, 0});
        tbl.push_back('{10'h000, 10, 0, 0, 0, 0, 10'h000, 1'b0, 7});
        tbl.push_back('{10'h024, 10, 0, 0, 0, 1, 10'h000, 1'b0, 0});
        tbl.push_back('{10'h000, 10, 0, 0, 0, 0, 10'h000, 1'b0, 0});
        tbl.push_back('{10'h001, 10, 1, 7, 7, 0, 10'h001, 1'b1, 0});
        tbl.push_back('{10'h000, 10, 0, 0, 0, 0, 10'h000, 1'b0, 7});
        tbl.push_back('{10'h200, 10, 1, 7, 7, 0, 10'h200, 1'b1, 0});
        tbl.push_back('{10'h202, 10, 0, 0, 0, 0, 10'h200, 1'b1, 0});
        tbl.push_back('{10'h000, 10, 0, 0, 0, 0, 10'h000, 1'b0, 6});

        repeat (3) @(posedge clk);
        #1;
        chk_idle_outputs("reset");
        rst_n = 1'b1;

        foreach (tbl[i]) begin
            apply(tbl[i].keys, tbl[i].n);
            chk($sformatf("v%0d.nstb", i), nstb, tbl[i].nstb);
            chk($sformatf("v%0d.first", i), first, tbl[i].first);
            chk($sformatf("v%0d.last", i), last, tbl[i].last);
            chk($sformatf("v%0d.nerr", i), nerr, tbl[i].nerr);
            chk($sformatf("v%0d.onehot", i), key_onehot, tbl[i].onehot);
            chk($sformatf("v%0d.valid", i), key_valid, tbl[i].valid);
            chk($sformatf("v%0d.fall", i), fall, tbl[i].fall);
        end

        // reset while key 4 is accepted, then re-debounce with the key still held
        apply(10'h010, 10);
        chk("rst.pre_first", first, 7);
        chk("rst.pre_onehot", key_onehot, 10'h010);
        rst_n = 1'b0;
        #1;
        chk_idle_outputs("rst.mid");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        apply(10'h010, 10);
        chk("rst.post_nstb", nstb, 1);
        chk("rst.post_first", first, 7);
        chk("rst.post_onehot", key_onehot, 10'h010);
        apply(10'h000, 10);
        chk("rst.rel_fall", fall, 7);

        // key 6 held for about 60 cycles after acceptance
        apply(10'h040, 64);
        chk("rep.first", first, 7);
`ifdef KEYPAD_REPEAT_EN
        chk("rep.nstb", nstb, 6);
        chk("rep.last", last, 59);
`else
        chk("rep.nstb", nstb, 1);
        chk("rep.last", last, 7);
`endif
        chk("rep.onehot", key_onehot, 10'h040);
        apply(10'h000, 10);
        chk("rep.rel_nstb", nstb, 0);
        chk("rep.rel_fall", fall, 7);

        chk("excl", both, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
